spi_device_core: RTL and testbench



---
 rtl/spi_device_core_if.sv | 14 +
 rtl/spi_device_core.sv | 213 +++++++++++++++++++++
 tb/tb_spi_device_core.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_device_core_if.sv
// Register-bus bundle for the SPI device core: byte-addressed single-cycle
// read/write strobes, registered read data and a bus-error pulse.
interface spi_device_core_if;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic [3:0]  be_i;
  logic        we_i;
  logic        re_i;
  logic        error_o;

  modport master (output addr_i, wdata_i, be_i, we_i, re_i, input rdata_o, error_o);
  modport slave  (input addr_i, wdata_i, be_i, we_i, re_i, output rdata_o, error_o);
endinterface

// File: rtl/spi_device_core.sv
// SPI device (responder) core: oversampled SCLK/SS/MOSI, shared TX/RX character engine,
// register bus for RX/TX/CTRL/STATUS. Define SPI_DEV_ADDR_ERR_EN to enable error_o pulses.
module spi_device_core #(
  parameter int MAX_CHAR    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  spi_device_core_if.slave bus,
  output logic             intr_o,
  input  logic             sclk_i,
  input  logic             ss_ni,
  input  logic             sd_i,
  output logic             sd_o,
  output logic             sd_oe_o
);
  localparam int CW = $clog2(MAX_CHAR);
  localparam int BW = $clog2(MAX_CHAR + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sreg, ss_sreg, sd_sreg;
  logic sclk_hist, ss_hist;

  logic [CW-1:0]       char_len_reg;
  logic                lsb_reg, rx_negedge_reg, tx_negedge_reg, ie_reg, en_reg;
  logic [MAX_CHAR-1:0] tx_buf_reg, rx_data_reg, tx_shreg_reg, rx_shreg_reg;
  logic                tx_empty_reg, rx_valid_reg, overrun_reg;
  logic [BW-1:0]       bit_cnt_reg, tx_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sreg <= '0;
      ss_sreg   <= '0;
      sd_sreg   <= '0;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b0;
    end else begin
      sclk_sreg <= {sclk_sreg[SYNC_STAGES-2:0], sclk_i};
      ss_sreg   <= {ss_sreg[SYNC_STAGES-2:0], ss_ni};
      sd_sreg   <= {sd_sreg[SYNC_STAGES-2:0], sd_i};
      sclk_hist <= sclk_sreg[SYNC_STAGES-1];
      ss_hist   <= ss_sreg[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, sd_s, sclk_rise, sclk_fall, ss_fall;
  assign sclk_s    = sclk_sreg[SYNC_STAGES-1];
  assign ss_s      = ss_sreg[SYNC_STAGES-1];
  assign sd_s      = sd_sreg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign ss_fall   = ~ss_s & ss_hist;

  logic active;
  assign active  = (state_reg == ACTIVE);
  assign sd_oe_o = active;

  // Register decode: only 0x00-0x0C are mapped; the byte offset is ignored.
  logic       mapped, wr_tx, wr_ctrl, wr_status, rd_rx;
  logic [1:0] reg_sel;
  logic       unused_bits;
  assign mapped      = (bus.addr_i[7:4] == 4'h0);
  assign reg_sel     = bus.addr_i[3:2];
  assign wr_tx       = bus.we_i & mapped & (reg_sel == 2'd1);
  assign wr_ctrl     = bus.we_i & mapped & (reg_sel == 2'd2);
  assign wr_status   = bus.we_i & mapped & (reg_sel == 2'd3);
  assign rd_rx       = bus.re_i & mapped & (reg_sel == 2'd0);
  assign unused_bits = ^bus.addr_i[1:0];

  logic start, leave;
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    leave      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en_reg && ss_fall) begin
          state_next = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (!en_reg || ss_s) begin
          state_next = IDLE;
          leave      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  logic [BW-1:0]       char_bits;
  logic [MAX_CHAR-1:0] char_mask, rx_shift;
  logic [CW-1:0]       top_idx, tx_idx;
  logic                sample, drive, complete, load;
  assign char_bits = (char_len_reg == '0) ? BW'(MAX_CHAR) : BW'(char_len_reg);
  assign char_mask = {MAX_CHAR{1'b1}} >> (BW'(MAX_CHAR) - char_bits);
  assign top_idx   = CW'(char_bits - BW'(1));
  assign tx_idx    = lsb_reg ? CW'(tx_cnt_reg) : CW'(char_bits - BW'(1) - tx_cnt_reg);
  assign sample    = active & ~leave & (rx_negedge_reg ? sclk_fall : sclk_rise);
  assign drive     = active & ~leave & (tx_negedge_reg ? sclk_fall : sclk_rise);
  assign complete  = sample & ((bit_cnt_reg + BW'(1)) == char_bits);
  assign load      = start | complete;
  assign sd_o      = active & tx_shreg_reg[tx_idx];

  always_comb begin
    rx_shift = {rx_shreg_reg[MAX_CHAR-2:0], sd_s};
    if (lsb_reg) begin
      rx_shift          = rx_shreg_reg >> 1;
      rx_shift[top_idx] = sd_s;
    end
  end

  logic [31:0] tx_buf_ext, tx_wr_val;
  assign tx_buf_ext = 32'(tx_buf_reg);
  for (genvar gi = 0; gi < 4; gi++) begin : g_tx_lane
    assign tx_wr_val[8*gi +: 8] = bus.be_i[gi] ? bus.wdata_i[8*gi +: 8] : tx_buf_ext[8*gi +: 8];
  end

  logic [31:0] rd_val;
  always_comb begin
    rd_val = '0;
    if (mapped) begin
      case (reg_sel)
        2'd0: rd_val = 32'(rx_data_reg);
        2'd2: begin
          rd_val[CW-1:0] = char_len_reg;
          rd_val[9:5]    = {en_reg, ie_reg, tx_negedge_reg, rx_negedge_reg, lsb_reg};
        end
        2'd3: rd_val[3:0] = {active, tx_empty_reg, overrun_reg, rx_valid_reg};
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      char_len_reg   <= '0;
      lsb_reg        <= 1'b0;
      rx_negedge_reg <= 1'b0;
      tx_negedge_reg <= 1'b0;
      ie_reg         <= 1'b0;
      en_reg         <= 1'b0;
      tx_buf_reg     <= '0;
      rx_data_reg    <= '0;
      tx_shreg_reg   <= '0;
      rx_shreg_reg   <= '0;
      tx_empty_reg   <= 1'b1;
      rx_valid_reg   <= 1'b0;
      overrun_reg    <= 1'b0;
      bit_cnt_reg    <= '0;
      tx_cnt_reg     <= '0;
      bus.rdata_o    <= '0;
      intr_o         <= 1'b0;
    end else begin
      if (wr_ctrl && !active) begin
        if (bus.be_i[0]) begin
          char_len_reg   <= bus.wdata_i[CW-1:0];
          lsb_reg        <= bus.wdata_i[5];
          rx_negedge_reg <= bus.wdata_i[6];
          tx_negedge_reg <= bus.wdata_i[7];
        end
        if (bus.be_i[1]) begin
          ie_reg <= bus.wdata_i[8];
          en_reg <= bus.wdata_i[9];
        end
      end
      if (wr_tx) tx_buf_reg <= MAX_CHAR'(tx_wr_val);
      // A TX write racing a load wins the empty flag; the load still takes the old buffer.
      if (wr_tx)     tx_empty_reg <= 1'b0;
      else if (load) tx_empty_reg <= 1'b1;
      if (load) tx_shreg_reg <= tx_empty_reg ? '0 : tx_buf_reg;
      if (start || leave || complete) begin
        bit_cnt_reg  <= '0;
        tx_cnt_reg   <= '0;
        rx_shreg_reg <= '0;
      end else begin
        if (sample) begin
          bit_cnt_reg  <= bit_cnt_reg + BW'(1);
          rx_shreg_reg <= rx_shift;
        end
        // Drive never runs ahead of sampling, so the pre-driven first bit is not skipped.
        if (drive && (tx_cnt_reg < bit_cnt_reg)) tx_cnt_reg <= tx_cnt_reg + BW'(1);
      end
      if (complete) rx_data_reg <= rx_shift & char_mask;
      if (complete)   rx_valid_reg <= 1'b1;
      else if (rd_rx) rx_valid_reg <= 1'b0;
      if (complete && rx_valid_reg && !rd_rx)                overrun_reg <= 1'b1;
      else if (wr_status && bus.be_i[0] && bus.wdata_i[1])  overrun_reg <= 1'b0;
      if (bus.re_i) bus.rdata_o <= rd_val;
      intr_o <= ie_reg & (rx_valid_reg | overrun_reg);
    end
  end

`ifdef SPI_DEV_ADDR_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bus.error_o <= 1'b0;
    else bus.error_o <= ((bus.re_i | bus.we_i) & ~mapped)
                      | (bus.we_i & mapped & (reg_sel == 2'd0))
                      | (wr_status & bus.be_i[0] & bus.wdata_i[0])
                      | (wr_ctrl & active);
  end
`else
  assign bus.error_o = 1'b0;
`endif
endmodule

// File: tb/tb_spi_device_core.sv
// Randomized scoreboard bench for spi_device_core: a transaction-level model predicts
// register reads and MISO characters; a monitor checks every read response.
module tb_spi_device_core;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, intr;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct { string name; logic [31:0] data; logic err; } exp_t;
  exp_t exp_q[$];
  logic re_d = 1'b0;

  logic [31:0] m_tx_buf, m_rx_data;
  logic        m_tx_empty, m_rx_valid, m_overrun, m_ie, m_lsb, m_modeb;
  int          m_len;
  logic [31:0] m_ctrl;

  spi_device_core_if bus();

  spi_device_core #(.MAX_CHAR(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(bus), .intr_o(intr),
    .sclk_i(sclk), .ss_ni(ss_n), .sd_i(mosi), .sd_o(miso), .sd_oe_o(miso_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endfunction

  always @(posedge clk) re_d <= bus.re_i;

  always @(negedge clk) begin
    exp_t e;
    if (re_d) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: got rdata 0x%08h, expected no read", bus.rdata_o);
      end else begin
        e = exp_q.pop_front();
        check(e.name, bus.rdata_o, e.data);
        check({e.name, "_err"}, 32'(bus.error_o), 32'(e.err));
        $display("[TB] read %s rdata=0x%08h err=%0b", e.name, bus.rdata_o, bus.error_o);
      end
    end
  end

  function automatic logic [31:0] mask_of(int len);
    return (len >= 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
  endfunction

  function automatic void m_reset();
    m_tx_buf = 0; m_rx_data = 0; m_tx_empty = 1; m_rx_valid = 0; m_overrun = 0;
    m_ie = 0; m_lsb = 0; m_modeb = 0; m_len = 32; m_ctrl = 0;
  endfunction

  function automatic logic [31:0] m_take_tx();
    logic [31:0] v;
    v = m_tx_empty ? 32'h0 : m_tx_buf;
    m_tx_empty = 1;
    return v;
  endfunction

  function automatic void m_complete(logic [31:0] v);
    if (m_rx_valid) m_overrun = 1;
    m_rx_data  = v & mask_of(m_len);
    m_rx_valid = 1;
  endfunction

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(logic [7:0] a, logic [31:0] d, logic [3:0] be);
    @(posedge clk); #1;
    bus.addr_i = a; bus.wdata_i = d; bus.be_i = be; bus.we_i = 1'b1;
    @(posedge clk); #1;
    bus.we_i = 1'b0; bus.be_i = 4'h0;
  endtask

  task automatic bus_read(logic [7:0] a, logic [31:0] expv, logic experr, string name);
    exp_q.push_back('{name, expv, experr});
    @(posedge clk); #1;
    bus.addr_i = a; bus.re_i = 1'b1;
    @(posedge clk); #1;
    bus.re_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic write_tx(logic [31:0] d, logic [3:0] be);
    bus_write(8'h04, d, be);
    for (int b = 0; b < 4; b++) if (be[b]) m_tx_buf[8*b +: 8] = d[8*b +: 8];
    m_tx_empty = 0;
    $display("[TB] write TX 0x%08h be=%b", d, be);
  endtask

  task automatic set_ctrl(int len, logic lsb, logic modeb, logic ie);
    logic [31:0] v;
    v = 32'(len % 32) | (32'(lsb) << 5) | (32'(modeb) << 6) | (32'(!modeb) << 7)
      | (32'(ie) << 8) | (32'h1 << 9);
    bus_write(8'h08, v, 4'h3);
    m_len = len; m_lsb = lsb; m_modeb = modeb; m_ie = ie; m_ctrl = v;
    $display("[TB] write CTRL 0x%03h", v);
  endtask

  task automatic read_status(string name);
    bus_read(8'h0C, {28'h0, 1'b0, m_tx_empty, m_overrun, m_rx_valid}, 1'b0, name);
  endtask

  task automatic read_rx(string name);
    bus_read(8'h00, m_rx_data, 1'b0, name);
    m_rx_valid = 0;
  endtask

  task automatic check_intr(string name);
    wait_clk(2);
    check(name, 32'(intr), 32'(m_ie & (m_rx_valid | m_overrun)));
  endtask

  // Host side of the link: drives MOSI and samples MISO on the edges opposite to the device.
  task automatic spi_bits(int nbits, logic [31:0] mosi_val, output logic [31:0] miso_val);
    int idx;
    miso_val = 0;
    for (int i = 0; i < nbits; i++) begin
      idx = m_lsb ? i : m_len - 1 - i;
      if (!m_modeb) begin
        mosi = mosi_val[idx];
        wait_clk(HALF);
        miso_val[idx] = miso;
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
      end else begin
        sclk = 1'b1;
        mosi = mosi_val[idx];
        wait_clk(HALF);
        miso_val[idx] = miso;
        sclk = 1'b0;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic frame(int n, logic [31:0] v0, logic [31:0] v1);
    logic [31:0] vals[2];
    logic [31:0] exp_miso, got;
    vals[0] = v0; vals[1] = v1;
    exp_miso = m_take_tx();
    ss_n = 1'b0;
    wait_clk(10);
    check("sd_oe_active", 32'(miso_oe), 32'h1);
    for (int c = 0; c < n; c++) begin
      spi_bits(m_len, vals[c], got);
      check("miso_char", got, exp_miso & mask_of(m_len));
      m_complete(vals[c]);
      $display("[TB] char len=%0d lsb=%0b modeb=%0b mosi=0x%08h miso=0x%08h", m_len, m_lsb, m_modeb,
               vals[c] & mask_of(m_len), got);
      exp_miso = m_take_tx();
    end
    wait_clk(4);
    ss_n = 1'b1;
    wait_clk(10);
    check("sd_oe_idle", 32'(miso_oe), 32'h0);
  endtask

  initial begin
    logic [31:0] got;
    bus.addr_i = 0; bus.wdata_i = 0; bus.be_i = 0; bus.we_i = 0; bus.re_i = 0;
    m_reset();
    wait_clk(3);
    rst_ni = 1'b1;
    wait_clk(2);

    // Reset state
    check("rst_rdata", bus.rdata_o, 32'h0);
    check("rst_intr", 32'(intr), 32'h0);
    check("rst_error", 32'(bus.error_o), 32'h0);
    check("rst_sd_o", 32'(miso), 32'h0);
    check("rst_sd_oe", 32'(miso_oe), 32'h0);
    read_status("rst_status");
    bus_read(8'h08, 32'h0, 1'b0, "rst_ctrl");
    read_rx("rst_rx");

    // Mode 0 character, MSB first
    set_ctrl(8, 0, 0, 0);
    write_tx(32'hA5, 4'hF);
    frame(1, 32'h3C, 32'h0);
    read_status("t1_status_valid");
    read_rx("t1_rx");
    read_status("t1_status_clear");

    // LSB first, falling-edge sampling, 32-bit character (CTRL=0x260)
    set_ctrl(32, 1, 1, 0);
    bus_read(8'h08, 32'h260, 1'b0, "t2_ctrl");
    frame(1, 32'h12345678, 32'h0);
    read_rx("t2_rx");

    // Overrun with interrupt
    set_ctrl(8, 0, 0, 1);
    frame(1, 32'h11, 32'h0);
    frame(1, 32'h22, 32'h0);
    read_status("t3_status_overrun");
    check_intr("t3_intr_set");
    bus_write(8'h0C, 32'h2, 4'h1);
    m_overrun = 0;
    read_status("t3_status_w1c");
    read_rx("t3_rx");
    check_intr("t3_intr_clear");

    // Abort after 5 of 8 bits
    set_ctrl(8, 0, 0, 0);
    write_tx(32'h77, 4'hF);
    void'(m_take_tx());
    ss_n = 1'b0;
    wait_clk(10);
    spi_bits(5, 32'hFF, got);
    ss_n = 1'b1;
    wait_clk(10);
    check("t4_sd_oe_abort", 32'(miso_oe), 32'h0);
    read_status("t4_status_abort");
    frame(1, 32'h96, 32'h0);
    read_rx("t4_rx_after_abort");

    // TX underflow and back-to-back characters
    write_tx(32'h5A, 4'hF);
    frame(2, 32'hC3, 32'h81);
    read_status("t5_status");
    read_rx("t5_rx");

    // Randomized characters: length, bit order, edge mode, byte-enabled TX writes
    for (int it = 0; it < 8; it++) begin
      logic [31:0] tx_d, v0, v1;
      logic [3:0] be;
      int nch;
      tx_d = $urandom; v0 = $urandom; v1 = $urandom;
      be = 4'($urandom_range(15, 1));
      nch = $urandom_range(2, 1);
      bus_write(8'h0C, 32'h2, 4'h1);
      m_overrun = 0;
      set_ctrl($urandom_range(32, 1), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)));
      if ($urandom_range(3, 0) != 0) write_tx(tx_d, be);
      frame(nch, v0, v1);
      read_status("rnd_status");
      check_intr("rnd_intr");
      read_rx("rnd_rx");
    end

    // Reset mid-frame
    set_ctrl(8, 0, 0, 1);
    bus_read(8'h08, m_ctrl, 1'b0, "t6_ctrl_before_reset");
    write_tx(32'hF0, 4'hF);
    void'(m_take_tx());
    ss_n = 1'b0;
    wait_clk(10);
    spi_bits(3, 32'hAA, got);
    check("t6_sd_oe_mid", 32'(miso_oe), 32'h1);
    @(posedge clk); #3;
    rst_ni = 1'b0;
    #1;
    check("t6_sd_oe_reset", 32'(miso_oe), 32'h0);
    check("t6_sd_o_reset", 32'(miso), 32'h0);
    check("t6_rdata_reset", bus.rdata_o, 32'h0);
    check("t6_intr_reset", 32'(intr), 32'h0);
    ss_n = 1'b1; sclk = 1'b0;
    wait_clk(3);
    rst_ni = 1'b1;
    m_reset();
    wait_clk(3);
    read_status("t6_status_after_reset");
    bus_read(8'h08, 32'h0, 1'b0, "t6_ctrl_after_reset");
`ifdef SPI_DEV_ADDR_ERR_EN
    bus_read(8'h10, 32'h0, 1'b1, "t6_unmapped");
`else
    bus_read(8'h10, 32'h0, 1'b0, "t6_unmapped");
`endif

    wait_clk(5);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
